// File: rtl/pipe_elastic_reg.sv
// Elastic valid/ready pipeline register: DEPTH-entry circular buffer
// carrying a WIDTH-bit payload stamped with an ORDER_W-bit commit tag.
//
// Ports:
//   clk, rst               clock, asynchronous active-low reset
//   in_valid/in_ready      upstream handshake, in_data payload
//   out_valid/out_ready    downstream handshake, out_data/out_order head
//   flush, flush_order     synchronous squash, new order counter value
//   count                  current occupancy
module pipe_elastic_reg #(
    parameter int WIDTH   = 32,
    parameter int DEPTH   = 2,
    parameter int ORDER_W = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [ORDER_W-1:0]         out_order,
    input  logic                       flush,
    input  logic [ORDER_W-1:0]         flush_order,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int ENT_W = WIDTH + ORDER_W;

    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    logic [ENT_W-1:0]   mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [ORDER_W-1:0] order_q, order_d;
    logic               push;
    logic               pop;

    // Explicit wrap so non power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(
        input logic [PTR_W-1:0] p
    );
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // Ready never looks at out_ready: no combinational path through
    // the stage, at the cost of a full buffer refusing while popping.
    assign in_ready  = (count_q != CNT_FULL) && !flush;
    assign out_valid = (count_q != '0) && !flush;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        order_d  = order_q;
        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
            order_d  = flush_order;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
                order_d  = order_q + ORDER_W'(1);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end
            unique case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            order_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            order_q  <= order_d;
        end
    end

    // Payload storage is deliberately left unreset; contents are only
    // meaningful while out_valid is high.
    generate
        if (DEPTH == 1) begin : g_single
            always_ff @(posedge clk) begin
                if (push) begin
                    mem_q[0] <= {in_data, order_q};
                end
            end
            assign {out_data, out_order} = mem_q[0];
        end else begin : g_multi
            always_ff @(posedge clk) begin
                if (push) begin
                    mem_q[wr_ptr_q] <= {in_data, order_q};
                end
            end
            assign {out_data, out_order} = mem_q[rd_ptr_q];
        end
    endgenerate

endmodule

// File: tb/tb_pipe_elastic_reg.sv
// Testbench for pipe_elastic_reg: three instances (DEPTH 4, 3, 1),
// directed scenarios plus randomized traffic against a queue model.
module tb_pipe_elastic_reg;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Instance A: WIDTH 32, DEPTH 4, ORDER_W 64
    logic        a_iv, a_ir, a_ov, a_or, a_fl;
    logic [31:0] a_id, a_od;
    logic [63:0] a_oo, a_fo;
    logic [2:0]  a_cnt;

    // Instance B: WIDTH 32, DEPTH 3, ORDER_W 4
    logic        b_iv, b_ir, b_ov, b_or, b_fl;
    logic [31:0] b_id, b_od;
    logic [3:0]  b_oo, b_fo;
    logic [1:0]  b_cnt;

    // Instance C: WIDTH 8, DEPTH 1, ORDER_W 8
    logic        c_iv, c_ir, c_ov, c_or, c_fl;
    logic [7:0]  c_id, c_od, c_oo, c_fo;
    logic [0:0]  c_cnt;

    pipe_elastic_reg #(.WIDTH(32), .DEPTH(4), .ORDER_W(64)) u_a (
        .clk(clk), .rst(rst),
        .in_valid(a_iv), .in_ready(a_ir), .in_data(a_id),
        .out_valid(a_ov), .out_ready(a_or), .out_data(a_od),
        .out_order(a_oo), .flush(a_fl), .flush_order(a_fo),
        .count(a_cnt)
    );

    pipe_elastic_reg #(.WIDTH(32), .DEPTH(3), .ORDER_W(4)) u_b (
        .clk(clk), .rst(rst),
        .in_valid(b_iv), .in_ready(b_ir), .in_data(b_id),
        .out_valid(b_ov), .out_ready(b_or), .out_data(b_od),
        .out_order(b_oo), .flush(b_fl), .flush_order(b_fo),
        .count(b_cnt)
    );

    pipe_elastic_reg #(.WIDTH(8), .DEPTH(1), .ORDER_W(8)) u_c (
        .clk(clk), .rst(rst),
        .in_valid(c_iv), .in_ready(c_ir), .in_data(c_id),
        .out_valid(c_ov), .out_ready(c_or), .out_data(c_od),
        .out_order(c_oo), .flush(c_fl), .flush_order(c_fo),
        .count(c_cnt)
    );

    task automatic idle_inputs();
        a_iv = 0; a_or = 0; a_fl = 0; a_id = '0; a_fo = '0;
        b_iv = 0; b_or = 0; b_fl = 0; b_id = '0; b_fo = '0;
        c_iv = 0; c_or = 0; c_fl = 0; c_id = '0; c_fo = '0;
    endtask

    // Leaves time at posedge + 1.
    task automatic do_reset();
        idle_inputs();
        rst = 1'b0;
        #2;
        rst = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_chk++; if (a_cnt !== 3'd0) begin n_fail++; $display("FAIL rst_count got %0d want 0", a_cnt); end
        n_chk++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL rst_out_valid got %b want 0", a_ov); end
        n_chk++; if (a_ir !== 1'b1) begin n_fail++; $display("FAIL rst_in_ready got %b want 1", a_ir); end
        #2;
        rst = 1'b1;
        #1;
        n_chk++; if (a_cnt !== 3'd0 || a_ov !== 1'b0 || a_ir !== 1'b1) begin n_fail++; $display("FAIL post_rst cnt=%0d ov=%b ir=%b want 0 0 1", a_cnt, a_ov, a_ir); end
        step();
        a_iv = 1; a_id = 32'hAAAA_0001;
        step();
        a_iv = 0;
        n_chk++; if (a_ov !== 1'b1) begin n_fail++; $display("FAIL first_valid got %b want 1", a_ov); end
        n_chk++; if (a_od !== 32'hAAAA_0001) begin n_fail++; $display("FAIL first_data got %0h want aaaa0001", a_od); end
        n_chk++; if (a_oo !== 64'd0) begin n_fail++; $display("FAIL first_order got %0d want 0", a_oo); end
    endtask

    task automatic test_fill_drain();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            a_iv = 1; a_id = 32'h10 + i;
            n_chk++; if (a_ir !== 1'b1) begin n_fail++; $display("FAIL fill_ready[%0d] got %b want 1", i, a_ir); end
            step();
        end
        a_iv = 1; a_id = 32'h99; a_or = 1;
        #1;
        n_chk++; if (a_ir !== 1'b0) begin n_fail++; $display("FAIL full_ready got %b want 0", a_ir); end
        n_chk++; if (a_cnt !== 3'd4) begin n_fail++; $display("FAIL full_count got %0d want 4", a_cnt); end
        for (int i = 0; i < 4; i++) begin
            n_chk++; if (a_ov !== 1'b1 || a_od !== 32'h10 + i || a_oo !== 64'(i)) begin n_fail++; $display("FAIL drain[%0d] ov=%b d=%0h t=%0d want 1 %0h %0d", i, a_ov, a_od, a_oo, 32'h10 + i, i); end
            step();
            a_iv = 0;
            n_chk++; if (a_cnt !== 3'(3 - i)) begin n_fail++; $display("FAIL drain_count[%0d] got %0d want %0d", i, a_cnt, 3 - i); end
        end
        a_or = 0;
        n_chk++; if (a_ov !== 1'b0) begin n_fail++; $display("FAIL drained_valid got %b want 0", a_ov); end
    endtask

    task automatic test_stream_wrap();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            b_iv = 1; b_or = 1; b_id = i;
            #1;
            if (i > 0) begin
                n_chk++; if (b_ov !== 1'b1 || b_od !== 32'(i - 1) || b_oo !== 4'(i - 1)) begin n_fail++; $display("FAIL stream[%0d] ov=%b d=%0d t=%0d want 1 %0d %0d", i, b_ov, b_od, b_oo, i - 1, i - 1); end
            end
            step();
            n_chk++; if (b_cnt !== 2'd1) begin n_fail++; $display("FAIL stream_count[%0d] got %0d want 1", i, b_cnt); end
        end
        b_iv = 0;
        n_chk++; if (b_od !== 32'd9) begin n_fail++; $display("FAIL stream_last got %0d want 9", b_od); end
        step();
        b_or = 0;
        n_chk++; if (b_cnt !== 2'd0) begin n_fail++; $display("FAIL stream_empty got %0d want 0", b_cnt); end
    endtask

    task automatic test_flush();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            b_iv = 1; b_or = 0; b_id = i;
            step();
            b_iv = 0; b_or = 1;
            step();
        end
        b_or = 0;
        for (int i = 0; i < 3; i++) begin
            b_iv = 1; b_id = 32'h50 + i;
            step();
        end
        n_chk++; if (b_oo !== 4'd5 || b_cnt !== 2'd3) begin n_fail++; $display("FAIL preflush tag=%0d cnt=%0d want 5 3", b_oo, b_cnt); end
        b_fl = 1; b_fo = 4'd6; b_iv = 1; b_id = 32'h77; b_or = 1;
        #1;
        n_chk++; if (b_ir !== 1'b0 || b_ov !== 1'b0) begin n_fail++; $display("FAIL flush_comb ir=%b ov=%b want 0 0", b_ir, b_ov); end
        step();
        b_fl = 0;
        n_chk++; if (b_cnt !== 2'd0 || b_ov !== 1'b0) begin n_fail++; $display("FAIL flush_after cnt=%0d ov=%b want 0 0", b_cnt, b_ov); end
        step();
        b_iv = 0;
        n_chk++; if (b_ov !== 1'b1 || b_od !== 32'h77 || b_oo !== 4'd6) begin n_fail++; $display("FAIL flush_tag ov=%b d=%0h t=%0d want 1 77 6", b_ov, b_od, b_oo); end
        b_or = 0;
    endtask

    task automatic test_async_reset();
        do_reset();
        a_iv = 1; a_id = 32'hB0;
        step();
        a_id = 32'hB1;
        step();
        a_iv = 0;
        n_chk++; if (a_cnt !== 3'd2 || a_ov !== 1'b1) begin n_fail++; $display("FAIL pre_async cnt=%0d ov=%b want 2 1", a_cnt, a_ov); end
        #2;
        rst = 1'b0;
        #1;
        n_chk++; if (a_ov !== 1'b0 || a_cnt !== 3'd0) begin n_fail++; $display("FAIL async_rst ov=%b cnt=%0d want 0 0", a_ov, a_cnt); end
        #1;
        rst = 1'b1;
        step();
        a_iv = 1; a_id = 32'hC0;
        step();
        a_iv = 0;
        n_chk++; if (a_ov !== 1'b1 || a_od !== 32'hC0 || a_oo !== 64'd0) begin n_fail++; $display("FAIL async_restart ov=%b d=%0h t=%0d want 1 c0 0", a_ov, a_od, a_oo); end
    endtask

    task automatic test_order_wrap();
        do_reset();
        for (int i = 0; i < 17; i++) begin
            b_iv = 1; b_or = 1; b_id = 32'h100 + i;
            step();
            b_iv = 0;
            n_chk++; if (b_ov !== 1'b1 || b_od !== 32'h100 + i || b_oo !== 4'(i % 16)) begin n_fail++; $display("FAIL wrap[%0d] ov=%b d=%0h t=%0d want 1 %0h %0d", i, b_ov, b_od, b_oo, 32'h100 + i, i % 16); end
            b_iv = 1;
        end
        b_iv = 0;
        step();
        b_or = 0;
    endtask

    task automatic test_depth1();
        do_reset();
        c_iv = 1; c_or = 1;
        for (int k = 0; k < 6; k++) begin
            c_id = 8'(k / 2 + 8'h40);
            #1;
            n_chk++; if (c_ir !== (k % 2 == 0) || c_ov !== (k % 2 == 1)) begin n_fail++; $display("FAIL depth1[%0d] ir=%b ov=%b want %b %b", k, c_ir, c_ov, k % 2 == 0, k % 2 == 1); end
            if (k % 2 == 1) begin
                n_chk++; if (c_od !== 8'(k / 2 + 8'h40) || c_oo !== 8'(k / 2)) begin n_fail++; $display("FAIL depth1_data[%0d] d=%0h t=%0d want %0h %0d", k, c_od, c_oo, k / 2 + 8'h40, k / 2); end
            end
            step();
        end
        c_iv = 0; c_or = 0;
    endtask

    task automatic test_random();
        logic [31:0] q_data[$];
        int          q_tag[$];
        int          ord;
        bit          exp_ir, exp_ov, push, pop;
        do_reset();
        ord  = 0;
        push = 1'b1;
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!b_iv || push) begin
                b_iv = ($urandom % 4) != 0;
                b_id = $urandom;
            end
            b_or = ($urandom % 3) != 0;
            b_fl = ($urandom % 25) == 0;
            b_fo = 4'($urandom);
            #1;
            exp_ir = (q_data.size() != 3) && !b_fl;
            exp_ov = (q_data.size() != 0) && !b_fl;
            n_chk++; if (b_ir !== exp_ir || b_ov !== exp_ov) begin n_fail++; $display("FAIL rnd_hs[%0d] ir=%b ov=%b want %b %b", cyc, b_ir, b_ov, exp_ir, exp_ov); end
            n_chk++; if (b_cnt !== 2'(q_data.size())) begin n_fail++; $display("FAIL rnd_cnt[%0d] got %0d want %0d", cyc, b_cnt, q_data.size()); end
            if (exp_ov) begin
                n_chk++; if (b_od !== q_data[0] || b_oo !== 4'(q_tag[0])) begin n_fail++; $display("FAIL rnd_head[%0d] d=%0h t=%0d want %0h %0d", cyc, b_od, b_oo, q_data[0], q_tag[0] % 16); end
            end
            push = b_iv && exp_ir;
            pop  = exp_ov && b_or;
            @(posedge clk);
            if (b_fl) begin
                q_data.delete();
                q_tag.delete();
                ord = int'(b_fo);
            end else begin
                if (pop) begin
                    void'(q_data.pop_front());
                    void'(q_tag.pop_front());
                end
                if (push) begin
                    q_data.push_back(b_id);
                    q_tag.push_back(ord);
                    ord = (ord + 1) % 16;
                end
            end
            #1;
        end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_fill_drain();
        test_stream_wrap();
        test_flush();
        test_async_reset();
        test_order_wrap();
        test_depth1();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
